// File: rtl/ram_port_arbiter.sv
// Shares one RAM port (sync write, combinational read) between CORE and a host/loader port.
// CORE has default priority; the host gains access via a starvation guard or holds the port
// with h_lock bursts. Define RAM_ARB_STATS_EN to add the conflict_cnt / stats_clr statistics.
module ram_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_stall,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic          h_lock,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic [DW-1:0] h_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
`ifdef RAM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   conflict_cnt,
`endif
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_HOST = 2'd2,
    ST_LOCK = 2'd3
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t     state_reg;
  logic [3:0] starve_cnt_reg;
  logic       locked;
  logic       forced;
  logic       host_grant;
  logic       core_grant;

  // Lock and a starved host both outrank CORE; otherwise CORE wins any tie.
  always_comb begin
    locked     = (state_reg == ST_LOCK);
    forced     = h_req && (starve_cnt_reg == MAX_W);
    host_grant = h_req && (locked || forced || !c_req);
    core_grant = c_req && !locked && !host_grant;
  end

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (core_grant) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (host_grant) begin
      m_we    = h_we;
      m_addr  = h_addr;
      m_wdata = h_wdata;
    end
  end

  assign c_stall = c_req && !core_grant;
  assign h_gnt   = host_grant;
  assign c_rdata = m_rdata;
  assign h_rdata = m_rdata;
  assign owner   = state_reg;

  // Ownership follows what was granted this cycle; a granted locked host keeps the port.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= ST_IDLE;
      starve_cnt_reg <= 4'd0;
    end else begin
      if (host_grant && h_lock)
        state_reg <= ST_LOCK;
      else if (core_grant)
        state_reg <= ST_CORE;
      else if (host_grant)
        state_reg <= ST_HOST;
      else
        state_reg <= ST_IDLE;

      if (!h_req || host_grant)
        starve_cnt_reg <= 4'd0;
      else if (starve_cnt_reg < MAX_W)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] conflict_cnt_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      conflict_cnt_reg <= 16'd0;
    else if (stats_clr)
      conflict_cnt_reg <= 16'd0;
    else if (c_stall && (conflict_cnt_reg != 16'hFFFF))
      conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
  end

  assign conflict_cnt = conflict_cnt_reg;
`endif

endmodule
